// File: rtl/cmd_buff_mc.sv
// Command-region write steering into NUM_CH per-channel command FIFOs, with a
// one-entry hold slot for writes that find their FIFO full.
module cmd_buff_mc #(
  parameter int          NUM_CH     = 4,
  parameter int          DEPTH      = 4,
  parameter int          DW         = 32,
  parameter int          AW         = 32,
  parameter int          CH_LSB     = 2,
  parameter logic [1:0]  CMD_REGION = 2'b01,
  localparam int         CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         PW         = $clog2(DEPTH),
  localparam int         LW         = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axi_wr_vld,
  output logic                 axi_wr_rdy,
  input  logic [AW-1:0]        axi_wr_addr,
  input  logic [DW-1:0]        axi_wr_data,
  input  logic [DW/8-1:0]      axi_wr_strb,
  input  logic [1:0]           axi_wr_region,
  output logic                 wr_done,
  output logic                 wr_err,
  output logic [NUM_CH-1:0]    out_vld,
  output logic [NUM_CH*DW-1:0] out_data,
  input  logic [NUM_CH-1:0]    out_rdy,
  output logic [NUM_CH*LW-1:0] ch_level
);

  logic [DW-1:0] mem_q    [NUM_CH][DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_CH];
  logic [PW-1:0] wr_ptr_d [NUM_CH];
  logic [PW-1:0] rd_ptr_q [NUM_CH];
  logic [PW-1:0] rd_ptr_d [NUM_CH];
  logic [LW-1:0] cnt_q    [NUM_CH];
  logic [LW-1:0] cnt_d    [NUM_CH];

  logic          hang_q, hang_d;
  logic [CW-1:0] hold_ch_q, hold_ch_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [CW-1:0]     ch_in, wch;
  logic [DW-1:0]     wdata;
  logic              ch_ok, acc, bad, want, push_any;
  logic [NUM_CH-1:0] push, pop, space;
  logic [AW-1:0]     unused_addr;

  assign unused_addr = axi_wr_addr;

  always_comb begin
    ch_in    = axi_wr_addr[CH_LSB +: CW];
    ch_ok    = ({1'b0, ch_in} < (CW+1)'(NUM_CH));
    acc      = axi_wr_vld & ~hang_q & (axi_wr_region == CMD_REGION);
    bad      = acc & (~(&axi_wr_strb) | ~ch_ok);
    // A held write has priority; new beats are blocked while hang_q is set.
    want     = hang_q | (acc & ~bad);
    wch      = hang_q ? hold_ch_q : ch_in;
    wdata    = hang_q ? hold_data_q : axi_wr_data;
    push     = '0;
    pop      = '0;
    space    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]      = (cnt_q[c] != '0) & out_rdy[c];
      space[c]    = (cnt_q[c] < LW'(DEPTH)) | pop[c];
      push[c]     = want & (wch == CW'(c)) & space[c];
      wr_ptr_d[c] = wr_ptr_q[c] + PW'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
      cnt_d[c]    = cnt_q[c] + LW'(push[c]) - LW'(pop[c]);
    end
    push_any    = |push;
    hang_d      = want & ~push_any;
    hold_ch_d   = hang_q ? hold_ch_q : ch_in;
    hold_data_d = hang_q ? hold_data_q : axi_wr_data;
    done_d      = bad | push_any;
    err_d       = bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hang_q      <= 1'b0;
      hold_ch_q   <= '0;
      hold_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      hang_q      <= hang_d;
      hold_ch_q   <= hold_ch_d;
      hold_data_q <= hold_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  // Storage needs no reset; contents only matter behind a valid count.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= wdata;
    end
  end

  assign axi_wr_rdy = ~hang_q;
  assign wr_done    = done_q;
  assign wr_err     = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign out_vld[g]           = (cnt_q[g] != '0);
    assign out_data[g*DW +: DW] = mem_q[g][rd_ptr_q[g]];
    assign ch_level[g*LW +: LW] = cnt_q[g];
  end

endmodule
